// File: rtl/alu_uart_sequencer_if.sv
// alu_uart_sequencer_if: UART RX/TX and ALU operand/result bundle for the sequencer
interface alu_uart_sequencer_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
);
    logic [NB_DATA-1:0]   rx_data;
    logic                 rx_valid;
    logic [NB_DATA-1:0]   alu_result;
    logic                 tx_busy;
    logic                 tx_done;
    logic [NB_DATA-1:0]   dato_a;
    logic [NB_DATA-1:0]   dato_b;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_DATA-1:0]   tx_data;
    logic                 tx_start;
    logic                 ready;
    logic                 overrun;
    modport master (
        input  rx_data, rx_valid, alu_result, tx_busy, tx_done,
        output dato_a, dato_b, opcode, tx_data, tx_start, ready, overrun
    );
    modport slave (
        output rx_data, rx_valid, alu_result, tx_busy, tx_done,
        input  dato_a, dato_b, opcode, tx_data, tx_start, ready, overrun
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects A, B, opcode bytes from UART RX, feeds the ALU and sends its result to UART TX
module alu_uart_sequencer #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input logic                  clk,
    input logic                  reset,
    alu_uart_sequencer_if.master bus
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 overrun_q, overrun_d;
    logic                 ready;
    logic                 rx_unused;
    assign ready     = state_q == WAIT_A || state_q == WAIT_B || state_q == WAIT_OP;
    assign rx_unused = ^bus.rx_data[NB_DATA-1:NB_OPCODE];
    always_comb begin
        state_d    = state_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q | (bus.rx_valid & ~ready);
        case (state_q)
            WAIT_A:  if (bus.rx_valid) begin
                dato_a_d = bus.rx_data;
                state_d  = WAIT_B;
            end
            WAIT_B:  if (bus.rx_valid) begin
                dato_b_d = bus.rx_data;
                state_d  = WAIT_OP;
            end
            WAIT_OP: if (bus.rx_valid) begin
                opcode_d = bus.rx_data[NB_OPCODE-1:0];
                state_d  = EXEC;
            end
            EXEC: begin
                tx_data_d = bus.alu_result;
                state_d   = SEND;
            end
            SEND:    if (!bus.tx_busy) begin
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            // a tx_done coinciding with our own start pulse cannot belong to this frame
            WAIT_TX: state_d = (bus.tx_done && !tx_start_q) ? WAIT_A : WAIT_TX;
            default: state_d = WAIT_A;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_A;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end
    assign bus.dato_a   = dato_a_q;
    assign bus.dato_b   = dato_b_q;
    assign bus.opcode   = opcode_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.ready    = ready;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: scoreboard bench with a behavioural ALU and scripted UART RX/TX
module tb_alu_uart_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int pulses = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    alu_uart_sequencer_if #(.NB_DATA(8), .NB_OPCODE(6)) bus();
    alu_uart_sequencer #(.NB_DATA(8), .NB_OPCODE(6)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.dato_a, bus.dato_b, bus.opcode);

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            pulses++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_start tx_data=%h (no result pending)", bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_tx_data got=%h want=%h", bus.tx_data, e);
                end
            end
            n_tests++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL tx_start_double got=1 want=0 in second cycle");
            end
        end
        prev_start = bus.tx_start;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = a;
        for (int i = 0; i < gap; i++) begin @(negedge clk); bus.rx_valid = 1'b0; end
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = b;
        for (int i = 0; i < gap; i++) begin @(negedge clk); bus.rx_valid = 1'b0; end
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = op;
        exp_q.push_back(alu_ref(a, b, op[5:0]));
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            lat++;
            if (bus.tx_start === 1'b1) break;
        end
        n_tests++;
        if (bus.tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_start_timeout got=%b want=1 after %0d cycles", bus.tx_start, lat);
        end
    endtask

    task automatic finish_tx();
        @(negedge clk); bus.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_busy = 1'b0; bus.tx_done = 1'b1;
        @(negedge clk); bus.tx_done = 1'b0;
        n_tests++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_done got=%b want=1", bus.ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dato_a", bus.dato_a, 8'h00);
        chk("rst_dato_b", bus.dato_b, 8'h00);
        chk("rst_opcode", {2'b00, bus.opcode}, 8'h00);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_tx_start", {7'd0, bus.tx_start}, 8'h00);
        chk("rst_overrun", {7'd0, bus.overrun}, 8'h00);
        chk("rst_ready", {7'd0, bus.ready}, 8'h01);
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat, p0;
        send3(8'h05, 8'h03, 8'h20, 2);
        p0 = pulses;
        wait_start(lat);
        chk("add_latency", lat[7:0], 8'd3);
        chk("add_dato_a", bus.dato_a, 8'h05);
        chk("add_dato_b", bus.dato_b, 8'h03);
        chk("add_opcode", {2'b00, bus.opcode}, 8'h20);
        chk("add_tx_data", bus.tx_data, 8'h08);
        finish_tx();
        chk("add_pulses", 8'(pulses - p0), 8'd1);
    endtask

    task automatic test_wrap();
        int lat;
        send3(8'hFF, 8'h02, 8'hE0, 0);
        wait_start(lat);
        chk("wrap_opcode", {2'b00, bus.opcode}, 8'h20);
        chk("wrap_tx_data", bus.tx_data, 8'h01);
        chk("wrap_latency", lat[7:0], 8'd3);
        finish_tx();
    endtask

    task automatic test_backpressure();
        int lat, p0, bad;
        bad = 0;
        bus.tx_busy = 1'b1;
        send3(8'h05, 8'h03, 8'h20, 0);
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (bus.tx_start !== 1'b0) bad++;
            if (i >= 1 && bus.tx_data !== 8'h08) bad++;
        end
        chk("bp_held_errors", bad[7:0], 8'd0);
        bus.tx_busy = 1'b0;
        wait_start(lat);
        chk("bp_release_latency", lat[7:0], 8'd1);
        chk("bp_tx_data", bus.tx_data, 8'h08);
        finish_tx();
        chk("bp_pulses", 8'(pulses - p0), 8'd1);
    endtask

    task automatic test_overrun();
        int lat;
        send3(8'h0A, 8'h0B, 8'h24, 0);
        wait_start(lat);
        chk("ovr_before", {7'd0, bus.overrun}, 8'h00);
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
        @(negedge clk); bus.rx_valid = 1'b0;
        chk("ovr_flag", {7'd0, bus.overrun}, 8'h01);
        chk("ovr_dato_a", bus.dato_a, 8'h0A);
        chk("ovr_dato_b", bus.dato_b, 8'h0B);
        chk("ovr_opcode", {2'b00, bus.opcode}, 8'h24);
        chk("ovr_tx_data", bus.tx_data, 8'h0A);
        finish_tx();
        send3(8'h01, 8'h01, 8'h20, 0);
        wait_start(lat);
        chk("ovr_next_tx_data", bus.tx_data, 8'h02);
        chk("ovr_sticky", {7'd0, bus.overrun}, 8'h01);
        finish_tx();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h44;
        @(negedge clk); bus.rx_data = 8'h55;
        @(negedge clk); bus.rx_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("mid_dato_a", bus.dato_a, 8'h00);
        chk("mid_dato_b", bus.dato_b, 8'h00);
        chk("mid_tx_data", bus.tx_data, 8'h00);
        chk("mid_overrun", {7'd0, bus.overrun}, 8'h00);
        chk("mid_ready", {7'd0, bus.ready}, 8'h01);
        reset = 1'b0;
        send3(8'h10, 8'h20, 8'h20, 0);
        wait_start(lat);
        chk("mid_tx_data_after", bus.tx_data, 8'h30);
        chk("mid_dato_a_after", bus.dato_a, 8'h10);
        finish_tx();
    endtask

    task automatic test_back_to_back();
        int lat;
        send3(8'h09, 8'h04, 8'h22, 0);
        wait_start(lat);
        chk("b2b_latency", lat[7:0], 8'd3);
        chk("b2b_tx_data", bus.tx_data, 8'h05);
        finish_tx();
        send3(8'hF0, 8'h0F, 8'h25, 0);
        wait_start(lat);
        chk("b2b_turnaround_latency", lat[7:0], 8'd3);
        chk("b2b_or_tx_data", bus.tx_data, 8'hFF);
        finish_tx();
    endtask

    initial begin
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
        test_reset();
        test_add();
        test_wrap();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        chk("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Byte-serial front end for the 8-bit ALU. It collects three bytes from the UART receiver (operand A, operand B, opcode) and drives them onto the ALU inputs from registers. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between the UART RX/TX pair and the combinational ALU at the top level.

## Interface
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OPCODE, 6, width of the ALU opcode field

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  NB_DATA  received byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe from UART RX
- alu_result  in  NB_DATA  combinational result from ALU output
- tx_busy  in  1  UART TX is shifting a frame
- tx_done  in  1  one-cycle strobe from UART TX at end of frame
- dato_a  out  NB_DATA  registered operand A to ALU
- dato_b  out  NB_DATA  registered operand B to ALU
- opcode  out  NB_OPCODE  registered opcode to ALU
- tx_data  out  NB_DATA  registered result byte to UART TX
- tx_start  out  1  registered one-cycle start pulse to UART TX
- ready  out  1  high in WAIT_A, WAIT_B, WAIT_OP
- overrun  out  1  sticky: a byte arrived while not accepting

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: when rx_valid is high, dato_a <= rx_data and the FSM moves to WAIT_B.
- WAIT_B: when rx_valid is high, dato_b <= rx_data and the FSM moves to WAIT_OP.
- WAIT_OP: when rx_valid is high, opcode <= rx_data[NB_OPCODE-1:0] and the FSM moves to EXEC. Upper rx_data bits are discarded without any check.
- EXEC: lasts exactly one cycle. tx_data <= alu_result, then the FSM moves to SEND.
- SEND: when tx_busy is low, tx_start <= 1 for one cycle and the FSM moves to WAIT_TX. When tx_busy is high, the FSM stays in SEND with tx_start at 0.
- WAIT_TX: on tx_done, the FSM moves to WAIT_A. tx_done in any other state is ignored.
- rx_valid in EXEC, SEND or WAIT_TX: the byte is dropped, overrun <= 1, and no register changes. overrun clears only on reset.
- Operands and opcode hold their values until overwritten by the next sequence. The ALU therefore sees stable inputs from EXEC through WAIT_TX.
- tx_data is stable from SEND until the next EXEC.
- No arithmetic is done inside the block. Width and wrap behaviour belong to the ALU, and alu_result is captured as-is.
- Reset values:
  - state = WAIT_A
  - dato_a = dato_b = tx_data = 0
  - opcode = 0
  - tx_start = 0, overrun = 0
  - ready = 1 (combinational from state)
- Reset asserted in any state, including mid-sequence or in WAIT_TX, aborts the operation and returns all outputs to their reset values on the next edge. A partial sequence is never resumed.

## Timing
- rx_valid for opcode sampled at edge N: state EXEC in cycle N+1, opcode valid at the ALU from N+1.
- alu_result is sampled at the edge ending cycle N+1, and tx_data is valid in cycle N+2 (state SEND).
- With tx_busy low in cycle N+2, tx_start is high in cycle N+3 only. Minimum latency from opcode strobe to tx_start is 3 cycles.
- tx_start is never high for two consecutive cycles and is never reasserted before tx_done.
- Back-to-back rx_valid on consecutive cycles in WAIT_A/B/OP is accepted, one byte per cycle.
- tx_done in the same cycle as tx_start is impossible by protocol and is ignored.
- Minimum turnaround from tx_done to accepting byte A: 1 cycle, with ready high the cycle after tx_done.

## Test plan
- ADD nominal:
  - Stimulus: bytes 0x05, 0x03, 0x20 (ALU connected), tx_busy low.
  - Required: dato_a=0x05, dato_b=0x03, opcode=0x20; tx_data=0x08; tx_start pulses exactly 3 cycles after the opcode strobe.
- Wrap and opcode truncation:
  - Stimulus: bytes 0xFF, 0x02, 0xE0.
  - Required: opcode=0x20, tx_data=0x01.
- TX backpressure:
  - Stimulus: tx_busy held high for 5 cycles after entering SEND.
  - Required: tx_start stays 0 during those cycles, then a single 1-cycle pulse. tx_data stays 0x08 throughout.
- Overrun:
  - Stimulus: rx_valid with 0x77 during WAIT_TX, then tx_done.
  - Required: overrun=1; dato_a, dato_b and opcode unchanged; state returns to WAIT_A. The next bytes 0x01, 0x01, 0x20 give tx_data=0x02 with overrun still 1.
- Reset mid-sequence:
  - Stimulus: reset after bytes A and B.
  - Required: all outputs zero, ready=1. The following bytes 0x10, 0x20, 0x20 give tx_data=0x30 with no stale operand.
- Back-to-back bytes:
  - Stimulus: three rx_valid strobes on consecutive cycles.
  - Required: all three are captured and tx_start fires with correct latency.
